// File: rtl/ram_ld_if.sv
// Loader bus: command inputs, local source/sink memory ports, UART byte streams
// and status. The master side is the loader itself.
interface ram_ld_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic            op_i;
    logic [31:0]     len_i;
    logic [XLEN-1:0] src_rd_addr_o;
    logic [7:0]      src_rd_data_i;
    logic [XLEN-1:0] dst_wr_addr_o;
    logic [7:0]      dst_wr_data_o;
    logic            dst_wr_en_o;
    logic [7:0]      uart_tx_data_o;
    logic            uart_tx_data_vld_o;
    logic            uart_tx_data_rdy_i;
    logic [7:0]      uart_rx_data_i;
    logic            uart_rx_data_vld_i;
    logic            uart_rx_data_rdy_o;
    logic            busy_o;
    logic            done_o;
    logic            timeout_o;

    modport master (
        input  start_i, op_i, len_i, src_rd_data_i, uart_tx_data_rdy_i,
               uart_rx_data_i, uart_rx_data_vld_i,
        output src_rd_addr_o, dst_wr_addr_o, dst_wr_data_o, dst_wr_en_o,
               uart_tx_data_o, uart_tx_data_vld_o, uart_rx_data_rdy_o,
               busy_o, done_o, timeout_o
    );

    modport slave (
        output start_i, op_i, len_i, src_rd_data_i, uart_tx_data_rdy_i,
               uart_rx_data_i, uart_rx_data_vld_i,
        input  src_rd_addr_o, dst_wr_addr_o, dst_wr_data_o, dst_wr_en_o,
               uart_tx_data_o, uart_tx_data_vld_o, uart_rx_data_rdy_o,
               busy_o, done_o, timeout_o
    );
endinterface

// File: rtl/ram_ld.sv
// UART memory loader: sends a 5-byte header (command + length), then either
// streams local source memory out over UART or writes received UART bytes
// into local sink memory, with an inter-byte idle timeout on receive.
module ram_ld #(
    parameter int unsigned XLEN    = 32,
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input logic    clk_i,
    input logic    rst_i,
    ram_ld_if.master bus
);
    typedef enum logic [2:0] {StIdle, StHdr, StFetch, StSend, StRecv, StFin} state_e;

    state_e          state_q;
    logic            op_q;
    logic [31:0]     len_q;
    logic [31:0]     idx_q;
    logic [31:0]     idle_q;
    logic [2:0]      hdr_q;
    logic [7:0]      tx_data_q;
    logic            tx_vld_q;
    logic            rx_rdy_q;
    logic            wr_en_q;
    logic [XLEN-1:0] wr_addr_q;
    logic [7:0]      wr_data_q;
    logic [XLEN-1:0] src_addr_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;

    logic [31:0]     idx_inc;
    logic [31:0]     idle_inc;
    logic            tx_fire;
    logic            rx_fire;

    // Incremented index/idle count and handshake completion
    always_comb begin
        idx_inc  = idx_q + 32'd1;
        idle_inc = idle_q + 32'd1;
        tx_fire  = tx_vld_q & bus.uart_tx_data_rdy_i;
        rx_fire  = rx_rdy_q & bus.uart_rx_data_vld_i;
    end

    // Transfer FSM with all outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            op_q       <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            idle_q     <= '0;
            hdr_q      <= '0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            rx_rdy_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            src_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_en_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        op_q      <= bus.op_i;
                        len_q     <= bus.len_i;
                        idx_q     <= '0;
                        hdr_q     <= '0;
                        busy_q    <= 1'b1;
                        tx_data_q <= bus.op_i ? 8'h52 : 8'h57;
                        tx_vld_q  <= 1'b1;
                        state_q   <= StHdr;
                    end
                end
                StHdr: begin
                    if (tx_fire) begin
                        if (hdr_q == 3'd4) begin
                            tx_vld_q <= 1'b0;
                            if (len_q == 32'd0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= StFin;
                            end else if (!op_q) begin
                                src_addr_q <= idx_q[XLEN-1:0];
                                state_q    <= StFetch;
                            end else begin
                                rx_rdy_q <= 1'b1;
                                idle_q   <= '0;
                                state_q  <= StRecv;
                            end
                        end else begin
                            // hdr_q counts bytes already sent; load the next length byte
                            hdr_q <= hdr_q + 3'd1;
                            case (hdr_q)
                                3'd0:    tx_data_q <= len_q[7:0];
                                3'd1:    tx_data_q <= len_q[15:8];
                                3'd2:    tx_data_q <= len_q[23:16];
                                default: tx_data_q <= len_q[31:24];
                            endcase
                        end
                    end
                end
                StFetch: begin
                    // Address has been stable for this whole cycle, read data is valid
                    tx_data_q <= bus.src_rd_data_i;
                    tx_vld_q  <= 1'b1;
                    state_q   <= StSend;
                end
                StSend: begin
                    if (tx_fire) begin
                        tx_vld_q <= 1'b0;
                        idx_q    <= idx_inc;
                        if (idx_inc == len_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFin;
                        end else begin
                            src_addr_q <= idx_inc[XLEN-1:0];
                            state_q    <= StFetch;
                        end
                    end
                end
                StRecv: begin
                    if (rx_fire) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q[XLEN-1:0];
                        wr_data_q <= bus.uart_rx_data_i;
                        idx_q     <= idx_inc;
                        idle_q    <= '0;
                        if (idx_inc == len_q) begin
                            rx_rdy_q <= 1'b0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= StFin;
                        end
                    end else if (idle_inc >= TIMEOUT) begin
                        rx_rdy_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        idle_q <= idle_inc;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.src_rd_addr_o      = src_addr_q;
    assign bus.dst_wr_addr_o      = wr_addr_q;
    assign bus.dst_wr_data_o      = wr_data_q;
    assign bus.dst_wr_en_o        = wr_en_q;
    assign bus.uart_tx_data_o     = tx_data_q;
    assign bus.uart_tx_data_vld_o = tx_vld_q;
    assign bus.uart_rx_data_rdy_o = rx_rdy_q;
    assign bus.busy_o             = busy_q;
    assign bus.done_o             = done_q;
    assign bus.timeout_o          = timeout_q;
endmodule

// File: doc/ram_ld.md
RAM_LD -- requirements
Module: ram_ld

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width of the source and sink memory ports.
REQ-002 SHALL have parameter TIMEOUT, default 32'd1000000, the maximum idle clock cycles allowed between received bytes in a read transfer.
REQ-003 clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  single-cycle transfer request, sampled in IDLE only.
REQ-006 op_i  in  1  0 = write to target (send bytes), 1 = read from target (receive bytes); captured with start_i.
REQ-007 len_i  in  32  byte count; captured with start_i.
REQ-008 src_rd_addr_o  out  XLEN  local source byte address; src_rd_data_i is valid one cycle later.
REQ-009 src_rd_data_i  in  8  local source read data.
REQ-010 dst_wr_addr_o / dst_wr_data_o / dst_wr_en_o  out  XLEN/8/1  local sink byte write port.
REQ-011 uart_tx_data_o / uart_tx_data_vld_o  out  8/1; uart_tx_data_rdy_i  in  1  byte stream to the UART transmitter.
REQ-012 uart_rx_data_i / uart_rx_data_vld_i  in  8/1; uart_rx_data_rdy_o  out  1  byte stream from the UART receiver.
REQ-013 busy_o  out  1  high from the cycle after start_i is accepted until return to IDLE.
REQ-014 done_o / timeout_o  out  1/1  single-cycle completion / abort pulses.

Function
REQ-015 States SHALL be IDLE, HDR, FETCH, SEND, RECV, FIN.
REQ-016 A byte SHALL transfer on a rising edge where vld and rdy are both high; while vld is high with rdy low, data SHALL be held stable.
REQ-017 IDLE: on start_i SHALL capture op_i and len_i, clear the byte index to 0, and go to HDR; start_i outside IDLE SHALL be ignored.
REQ-018 HDR SHALL send 5 bytes in order: command (0x57 for op 0, 0x52 for op 1), then len bytes [7:0], [15:8], [23:16], [31:24].
REQ-019 After the header: len = 0 -> FIN; op 0 -> FETCH; op 1 -> RECV.
REQ-020 FETCH SHALL drive src_rd_addr_o = index for one cycle, then go to SEND with uart_tx_data_o = src_rd_data_i registered.
REQ-021 SEND: on transfer, index increments; index = len -> FIN, otherwise -> FETCH (1 byte per at most 2 cycles + rdy wait).
REQ-022 RECV SHALL hold uart_rx_data_rdy_o high; on transfer SHALL pulse dst_wr_en_o for one cycle with dst_wr_addr_o = index and dst_wr_data_o = byte, then increment index; index = len -> FIN.
REQ-023 uart_rx_data_rdy_o SHALL be low in every state other than RECV.
REQ-024 RECV SHALL count idle cycles and clear the count on every received byte; count reaching TIMEOUT SHALL pulse timeout_o, return to IDLE, and suppress done_o.
REQ-025 FIN SHALL pulse done_o for exactly one cycle and return to IDLE; busy_o falls in the same cycle done_o or timeout_o is high.
REQ-026 Index and length arithmetic SHALL be 32-bit unsigned; src/dst address SHALL be index[XLEN-1:0].
REQ-027 A byte arriving on uart_rx while not in RECV SHALL stay unaccepted (rdy low) and SHALL not be written.

Reset
REQ-028 On rst_i assertion, at any time including mid-transfer, the state SHALL go to IDLE immediately and all outputs SHALL be 0 (addresses, data, vld, rdy, wr_en, busy_o, done_o, timeout_o).
REQ-029 After rst_i deasserts, the first transfer SHALL require a new start_i; no partial frame SHALL resume.

Verification
REQ-030 op 0, len 3, source bytes 0xA1,0xB2,0xC3, rdy always high -> tx stream 0x57,0x03,0x00,0x00,0x00,0xA1,0xB2,0xC3, then one done_o pulse.
REQ-031 op 1, len 2, rx bytes 0x11,0x22 -> tx header 0x52,0x02,0x00,0x00,0x00; dst writes (0,0x11),(1,0x22); one done_o pulse.
REQ-032 op 0, len 2, uart_tx_data_rdy_i held low for 10 cycles on every byte -> data/vld stable during stall, no byte lost or duplicated.
REQ-033 op 1, len 4, only 1 byte sent, TIMEOUT = 16 -> timeout_o pulse 16 cycles after last byte, no done_o, busy_o low, one dst write.
REQ-034 op 0, len 0 -> header only, done_o pulse, no src reads; start_i while busy -> ignored; rst_i during SEND -> all outputs 0 asynchronously.
